vram_axis_reader: RTL and testbench

Frame-buffer readout engine: scans the video RAM in raster order and emits every pixel as an AXI4-Stream master byte stream. It is the transmit counterpart of the AXI4-Stream VRAM write port. Each pixel goes out as three bytes: blue, green, red, in that order. The stream wire format matches the one the VRAM write port accepts, so a captured frame can be looped back unchanged. It sits between the pixel RAM read port and a DMA/UART/loopback consumer.

---
 rtl/vram_axis_reader.sv | 164 ++++++++++++++++
 tb/tb_vram_axis_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : vram_axis_reader
// Purpose  : Raster-order frame-buffer readout, emitted as an 8-bit
//            AXI4-Stream master (blue, green, red per pixel).
// Revision : 1.0 - initial release
// ============================================================================
module vram_axis_reader #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        vram_rd,
    output logic [10:0] vram_col,
    output logic [9:0]  vram_row,
    input  logic [7:0]  vram_red,
    input  logic [7:0]  vram_green,
    input  logic [7:0]  vram_blue,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic [7:0]  axis_tdata,
    output logic        axis_tstrb,
    output logic        axis_tkeep,
    output logic        axis_tlast
);

    generate
        if (H_ACTIVE < 1 || H_ACTIVE > 2048 || V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_bad_geometry
            $error("vram_axis_reader: H_ACTIVE must be 1..2048 and V_ACTIVE 1..1024");
        end
    endgenerate

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  ROW_LAST = 10'(V_ACTIVE - 1);

    logic [1:0]       state_q, state_d;
    logic [10:0]      col_q, col_d;
    logic [9:0]       row_q, row_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic [1:0]       occ_q, occ_d;
    logic [1:0]       byte_q, byte_d;
    logic [1:0][24:0] ent_q, ent_d;     // {last, red, green, blue}; entry 0 is the head
    logic             done_q, done_d;

    logic       rd;
    logic       at_last;
    logic       tvalid;
    logic       tlast;
    logic       hs;
    logic       pop;
    logic [1:0] occ_after;

    always_comb begin
        // Reserve a slot for every read in flight so returning data always fits.
        rd      = (state_q == ST_RUN) && ((occ_q + {1'b0, inflight_q}) < 2'd2);
        at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
        tvalid  = (occ_q != 2'd0);
        tlast   = tvalid && (byte_q == 2'd2) && ent_q[0][24];
        hs      = tvalid && axis_tready;
        pop     = hs && (byte_q == 2'd2);

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = 11'd0;
                    row_d   = 10'd0;
                end
            end
            ST_RUN: begin
                if (rd) begin
                    if (at_last) begin
                        state_d = ST_DRAIN;
                    end else if (col_q == COL_LAST) begin
                        col_d = 11'd0;
                        row_d = row_q + 10'd1;
                    end else begin
                        col_d = col_q + 11'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        inflight_d      = rd;
        inflight_last_d = rd && at_last;

        byte_d = byte_q;
        if (hs) begin
            byte_d = (byte_q == 2'd2) ? 2'd0 : byte_q + 2'd1;
        end

        occ_after = occ_q - {1'b0, pop};
        ent_d     = ent_q;
        if (pop) begin
            ent_d[0] = ent_q[1];
        end
        if (inflight_q) begin
            ent_d[occ_after[0]] = {inflight_last_q, vram_red, vram_green, vram_blue};
        end
        occ_d  = occ_after + {1'b0, inflight_q};
        done_d = hs && tlast;
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_q         <= ST_IDLE;
            col_q           <= 11'd0;
            row_q           <= 10'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            byte_q          <= 2'd0;
            ent_q           <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            byte_q          <= byte_d;
            ent_q           <= ent_d;
            done_q          <= done_d;
        end
    end

    always_comb begin
        case (byte_q)
            2'd0:    axis_tdata = tvalid ? ent_q[0][7:0]   : 8'd0;
            2'd1:    axis_tdata = tvalid ? ent_q[0][15:8]  : 8'd0;
            default: axis_tdata = tvalid ? ent_q[0][23:16] : 8'd0;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign vram_rd     = rd;
    assign vram_col    = col_q;
    assign vram_row    = row_q;
    assign axis_tvalid = tvalid;
    assign axis_tstrb  = tvalid;
    assign axis_tkeep  = tvalid;
    assign axis_tlast  = tlast;

endmodule
`default_nettype wire

// File: tb/tb_vram_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_axis_reader
// Purpose  : Self-checking bench for vram_axis_reader on a 4x2 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_axis_reader;

    localparam int H      = 4;
    localparam int V      = 2;
    localparam int NPIX   = H * V;
    localparam int NBYTES = 3 * NPIX;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        tready = 1'b1;
    logic        busy, frame_done, vram_rd;
    logic [10:0] vram_col;
    logic [9:0]  vram_row;
    logic [7:0]  vram_red = 8'd0, vram_green = 8'd0, vram_blue = 8'd0;
    logic        tvalid, tstrb, tkeep, tlast;
    logic [7:0]  tdata;

    logic [23:0] mem [NPIX];          // {red, green, blue}
    int n_tests = 0, n_fail = 0;
    int ready_mode = 0;               // 0: always ready, 1: random, 2: held low

    // reference model state
    bit         mon_en = 1'b0;
    bit         busy_exp = 1'b0, fd_exp = 1'b0;
    int         iss = 0, iss_prev = 0, popped = 0, byte_idx = 0;
    bit         stall_prev = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'd0;
    bit         lat_armed = 1'b0;
    int         lat_cnt = 0, done_cnt = 0;

    vram_axis_reader #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (aresetn),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .vram_rd      (vram_rd),
        .vram_col     (vram_col),
        .vram_row     (vram_row),
        .vram_red     (vram_red),
        .vram_green   (vram_green),
        .vram_blue    (vram_blue),
        .axis_tvalid  (tvalid),
        .axis_tready  (tready),
        .axis_tdata   (tdata),
        .axis_tstrb   (tstrb),
        .axis_tkeep   (tkeep),
        .axis_tlast   (tlast)
    );

    always #5 clk = ~clk;

    // pixel RAM with one cycle read latency
    always @(posedge clk) begin
        if (vram_rd) begin
            vram_red   <= mem[(int'(vram_row) * H + int'(vram_col)) % NPIX][23:16];
            vram_green <= mem[(int'(vram_row) * H + int'(vram_col)) % NPIX][15:8];
            vram_blue  <= mem[(int'(vram_row) * H + int'(vram_col)) % NPIX][7:0];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       tready = 1'b1;
                1:       tready = 1'($urandom_range(1, 0));
                default: tready = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        logic [23:0] px;
        px = mem[idx / 3];
        case (idx % 3)
            0:       return px[7:0];
            1:       return px[15:8];
            default: return px[23:16];
        endcase
    endfunction

    // Stream-level reference: pixels become available two cycles after their
    // read, leave in B,G,R order, and at most two pixels are read but unsent.
    always @(negedge clk) begin : monitor
        bit was_busy, exp_rd, exp_v, hs;
        if (mon_en) begin
            was_busy = busy_exp;
            check("busy", busy, busy_exp);
            check("frame_done", frame_done, fd_exp);
            if (frame_done) done_cnt++;

            exp_rd = busy_exp && (iss < NPIX) && ((iss - popped) < 2);
            check("vram_rd", vram_rd, exp_rd);
            if (vram_rd) begin
                check("rd_row", vram_row, iss / H);
                check("rd_col", vram_col, iss % H);
            end

            exp_v = (iss_prev > popped);
            check("tvalid", tvalid, exp_v);
            check("tstrb", tstrb, exp_v);
            check("tkeep", tkeep, exp_v);

            if (stall_prev) begin
                check("hold_tvalid", tvalid, 1);
                check("hold_tdata", tdata, prev_data);
                check("hold_tlast", tlast, prev_last);
            end

            if (lat_armed) begin
                lat_cnt++;
                if (lat_cnt == 3) begin
                    check("latency", tvalid, 1);
                    lat_armed = 1'b0;
                end
            end

            hs     = tvalid && tready;
            fd_exp = 1'b0;
            if (hs && byte_idx < NBYTES) begin
                check("tdata", tdata, exp_byte(byte_idx));
                check("tlast", tlast, byte_idx == NBYTES - 1);
                byte_idx++;
                if (byte_idx % 3 == 0) popped++;
                if (byte_idx == NBYTES) begin
                    fd_exp   = 1'b1;
                    busy_exp = 1'b0;
                end
            end

            stall_prev = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            iss_prev   = iss;
            if (vram_rd) iss++;

            if (start && !was_busy) begin
                busy_exp  = 1'b1;
                iss       = 0;
                iss_prev  = 0;
                popped    = 0;
                byte_idx  = 0;
                lat_armed = 1'b1;
                lat_cnt   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check("frame_done_timeout", done_cnt != d0, 1);
    endtask

    task automatic wait_bytes(input int nb);
        int n;
        n = 0;
        while (byte_idx < nb && n < 200) begin
            tick();
            n++;
        end
        check("byte_wait_timeout", byte_idx >= nb, 1);
    endtask

    task automatic fill_pattern();
        for (int n = 0; n < NPIX; n++)
            mem[n] = {8'(8'h30 + n), 8'(8'h20 + n), 8'(8'h10 + n)};
    endtask

    task automatic fill_random();
        for (int n = 0; n < NPIX; n++)
            mem[n] = 24'($urandom);
    endtask

    task automatic model_clear();
        busy_exp   = 1'b0;
        fd_exp     = 1'b0;
        iss        = 0;
        iss_prev   = 0;
        popped     = 0;
        byte_idx   = 0;
        stall_prev = 1'b0;
        lat_armed  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        @(negedge clk);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_vram_rd"}, vram_rd, 0);
        check({pfx, "_vram_col"}, vram_col, 0);
        check({pfx, "_vram_row"}, vram_row, 0);
        check({pfx, "_tvalid"}, tvalid, 0);
        check({pfx, "_tdata"}, tdata, 0);
        check({pfx, "_tstrb"}, tstrb, 0);
        check({pfx, "_tkeep"}, tkeep, 0);
        check({pfx, "_tlast"}, tlast, 0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d;
        fill_pattern();
        repeat (3) tick();
        check_idle_outputs("rst");
        tick();
        aresetn = 1'b1;
        mon_en  = 1'b1;
        tick();

        // pattern frame, always ready
        ready_mode = 0;
        pulse_start();
        wait_done(200);
        check("frame1_bytes", byte_idx, NBYTES);
        tick();
        check("frame1_busy_after", busy, 0);

        // random back-pressure, alternating pattern and random pixel data
        ready_mode = 1;
        for (int f = 0; f < 1000; f++) begin
            if (f % 2 == 0) fill_pattern();
            else            fill_random();
            pulse_start();
            wait_done(400);
            check("rand_frame_bytes", byte_idx, NBYTES);
        end

        // long stall mid-frame
        ready_mode = 0;
        fill_pattern();
        tick();
        pulse_start();
        wait_bytes(6);
        ready_mode = 2;
        repeat (20) tick();
        @(negedge clk);
        check("stall_vram_rd", vram_rd, 0);
        check("stall_tvalid", tvalid, 1);
        tick();
        ready_mode = 0;
        wait_done(200);
        check("stall_frame_bytes", byte_idx, NBYTES);

        // start while busy is ignored
        fill_random();
        d = done_cnt;
        pulse_start();
        repeat (5) tick();
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done(200);
        repeat (40) tick();
        check("single_frame", done_cnt - d, 1);
        check("idle_after_single", busy, 0);
        fill_random();
        pulse_start();
        wait_done(200);
        check("second_frame_bytes", byte_idx, NBYTES);

        // reset in the middle of a frame
        fill_pattern();
        tick();
        d = done_cnt;
        pulse_start();
        wait_bytes(10);
        aresetn = 1'b0;
        mon_en  = 1'b0;
        tick();
        aresetn = 1'b1;
        check_idle_outputs("abort");
        model_clear();
        mon_en = 1'b1;
        tick();
        repeat (10) tick();
        check("abort_no_done", done_cnt - d, 0);
        pulse_start();
        wait_done(200);
        check("after_abort_bytes", byte_idx, NBYTES);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
